nano_lsu_mc: RTL and testbench
==============================

# nano_lsu_mc

Multi-cycle load/store unit for the nano_rv32i core: replaces the single-cycle, combinational data-memory path with a registered bus master. It handles all RV32I load and store widths, byte-enable generation, sign and zero extension, misalignment detection, and a wait-state handshake with timeout. It sits between the core's execute stage (ALU address, rs2 data, funct3) and the data-memory port. It stalls the PC through `busy_o` until the access completes.

## Interface
Parameters:
- ADDR_W, 32, data bus address width
- TIMEOUT, 16, cycles allowed in BUS without `d_ack_i`/`d_err_i`; 0 disables the timeout

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low (`clk_i`, `rst_n_i`).
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- req_i  in  1  access request; core holds it with stable operands until `done_o` or `err_o`
- we_i  in  1  1 = store, 0 = load
- funct3_i  in  3  RV32I width/sign field
- addr_i  in  ADDR_W  effective address (ALU result)
- wdata_i  in  32  store data (rs2)
- rdata_o  out  32  extended load result; valid in the `done_o` cycle and held until the next load completes
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle error pulse, mutually exclusive with `done_o`
- err_cause_o  out  2  01 misaligned/illegal funct3, 10 timeout, 11 bus error; held until the next `err_o`
- busy_o  out  1  `req_i & ~(done_o | err_o)`; combinational stall to the PC
- d_addr_o  out  ADDR_W  word-aligned bus address (`addr_i[1:0]` forced to 00)
- d_data_o  out  32  lane-replicated store data
- d_be_o  out  4  byte enables
- d_rd_o  out  1  read strobe
- d_wr_o  out  1  write strobe
- d_data_i  in  32  read data, sampled with `d_ack_i`
- d_ack_i  in  1  access complete
- d_err_i  in  1  bus error

## Operation
- FSM states: IDLE, BUS, RESP, FAULT.
- IDLE:
  - On `req_i` with a legal, aligned access: register address, byte enables and data, then go to BUS.
  - On `req_i` with an illegal or misaligned access: go to FAULT with cause 01.
- BUS:
  - `d_rd_o`/`d_wr_o` asserted with stable `d_addr_o`/`d_be_o`/`d_data_o`.
  - On `d_ack_i`: capture the extended data and go to RESP.
  - On `d_err_i`: go to FAULT with cause 11. `d_err_i` wins if it coincides with `d_ack_i`.
  - When the timeout counter reaches TIMEOUT: go to FAULT with cause 10.
- RESP: `done_o` = 1; return to IDLE. `req_i` is ignored in this cycle.
- FAULT: `err_o` = 1; return to IDLE. Strobes are already low.
- Store formatting:
  - SB (000): be = 1 << addr[1:0], data = {4{wdata[7:0]}}.
  - SH (001): be = addr[1] ? 1100 : 0011, data = {2{wdata[15:0]}}.
  - SW (010): be = 1111.
- Load extraction, where the lane is selected by addr[1:0]:
  - LB (000) sign-extends and LBU (100) zero-extends the selected byte.
  - LH (001) sign-extends and LHU (101) zero-extends the selected half.
  - LW (010) passes the word through.
  - Loads drive be = 1111.
- Illegal funct3: loads 011/110/111; stores with funct3 outside 000–010.
- Misaligned: halfword access with addr[0] = 1; word access with addr[1:0] ≠ 00.
- `d_ack_i`/`d_err_i` are ignored outside BUS.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counter 0.
- Reset assertion mid-access drops the strobes immediately (asynchronous). No `done_o` or `err_o` is generated.
- Bus outputs are registered.
- Request sampled in IDLE at cycle 0:
  - Strobes assert at cycle 1.
  - `d_ack_i` at cycle k ≥ 1 gives `done_o` at k+1.
  - Minimum latency is 2 cycles; the next request is accepted at k+2.
- Misalignment raises `err_o` at cycle 1; no bus strobe is ever asserted.
- Timeout counter:
  - Width $clog2(TIMEOUT+1); clears on entry to BUS.
  - Counts each BUS cycle without a response; `err_o` fires TIMEOUT+1 cycles after the strobe asserts.
- `d_addr_o` is held stable for the whole BUS stay.

## Structure
- Shared package `nano_rv32i_pkg`: funct3 constants (LB…SW), error cause codes, FSM state encodings.
- One sub-module, `lsu_align`: purely combinational; produces store byte enables and lane data, load extraction/extension, and the illegal/misaligned flag. The top level holds the FSM, registers and counter.

## Test plan
- SB, addr 0x103, wdata 0xA5, ack at the first BUS cycle → d_addr_o 0x100, d_be_o 1000, d_data_o 0xA5A5A5A5, `done_o` 2 cycles after `req_i`.
- LB and LBU, addr 0x102, d_data_i 0x00800000 → rdata_o 0xFFFFFF80 and 0x00000080 respectively.
- LH, addr 0x101 → `err_o`, cause 01, next cycle; d_rd_o never asserted.
- LW, TIMEOUT = 4, no ack → `err_o` cause 10 five cycles after the strobe asserts; strobes drop.
- SW with `d_ack_i` = `d_err_i` = 1 in the same cycle → `err_o` cause 11; no `done_o`.
- `rst_n_i` low during BUS → strobes 0 immediately; after release the FSM is in IDLE and a fresh LW completes normally.

Source files
------------

// File: rtl/nano_lsu_mc_pkg.sv
// Shared definitions for the nano_rv32i load/store path.
// Contents: RV32I load/store funct3 codes, error cause codes and the
// LSU FSM state type. No ports.
package nano_rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_BUSERR   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_BUS   = 2'b01,
    S_RESP  = 2'b10,
    S_FAULT = 2'b11
  } lsu_state_t;

endpackage

// File: rtl/nano_lsu_mc_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
// Master drives d_addr_o, d_data_o, d_be_o, d_rd_o, d_wr_o;
// slave drives d_data_i, d_ack_i, d_err_i.
interface nano_lsu_mc_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic [ADDR_W-1:0] d_addr_o;
  logic [31:0]       d_data_o;
  logic [3:0]        d_be_o;
  logic              d_rd_o;
  logic              d_wr_o;
  logic [31:0]       d_data_i;
  logic              d_ack_i;
  logic              d_err_i;

  modport master (
    output d_addr_o, d_data_o, d_be_o, d_rd_o, d_wr_o,
    input  d_data_i, d_ack_i, d_err_i
  );

  modport slave (
    input  d_addr_o, d_data_o, d_be_o, d_rd_o, d_wr_o,
    output d_data_i, d_ack_i, d_err_i
  );

endinterface

// File: rtl/nano_lsu_mc_align.sv
// Combinational lane logic for the LSU.
// Inputs : we (store), funct3, addr_lo (addr[1:0]), wdata (rs2),
//          rdata (raw bus word).
// Outputs: be (byte enables), wlane (replicated store data),
//          rext (extracted/extended load data), bad (illegal funct3
//          or misaligned access).
module lsu_align
  import nano_rv32i_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rext,
  output logic        bad
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    case (addr_lo)
      2'd0:    sel_b = rdata[7:0];
      2'd1:    sel_b = rdata[15:8];
      2'd2:    sel_b = rdata[23:16];
      default: sel_b = rdata[31:24];
    endcase
    sel_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be    = '0;
    wlane = wdata;
    rext  = rdata;
    bad   = 1'b0;
    if (we) begin
      case (funct3)
        F3_SB: begin
          be    = 4'b0001 << addr_lo;
          wlane = {4{wdata[7:0]}};
        end
        F3_SH: begin
          be    = addr_lo[1] ? 4'b1100 : 4'b0011;
          wlane = {2{wdata[15:0]}};
          bad   = addr_lo[0];
        end
        F3_SW: begin
          be  = '1;
          bad = (addr_lo != 2'b00);
        end
        default: bad = 1'b1;
      endcase
    end else begin
      be = '1;
      case (funct3)
        F3_LB:   rext = {{24{sel_b[7]}}, sel_b};
        F3_LBU:  rext = {24'd0, sel_b};
        F3_LH: begin
          rext = {{16{sel_h[15]}}, sel_h};
          bad  = addr_lo[0];
        end
        F3_LHU: begin
          rext = {16'd0, sel_h};
          bad  = addr_lo[0];
        end
        F3_LW:   bad = (addr_lo != 2'b00);
        default: bad = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/nano_lsu_mc.sv
// Multi-cycle load/store unit: registered data-memory bus master with
// byte enables, load extension, misalignment detection and a wait-state
// timeout.
// Ports: clk_i, rst_n_i (async active-low); core side req_i, we_i,
// funct3_i, addr_i, wdata_i, rdata_o, done_o, err_o, err_cause_o,
// busy_o; data bus through the bus interface (master modport).
module nano_lsu_mc
  import nano_rv32i_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_cause_o,
  output logic              busy_o,
  nano_lsu_mc_if.master     bus
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  lsu_state_t        state, state_n;
  logic [1:0]        cause_n;
  logic [CW-1:0]     cnt;
  logic              to_hit;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [3:0]        be_q;
  logic              rd_q, wr_q;
  logic [31:0]       rdata_q;
  logic [1:0]        cause_q;

  logic [3:0]  al_be;
  logic [31:0] al_wlane, al_rext;
  logic        al_bad;

  // Operands are held stable by the core for the whole access, so one
  // aligner instance serves both request formatting and load extraction.
  lsu_align u_align (
    .we      (we_i),
    .funct3  (funct3_i),
    .addr_lo (addr_i[1:0]),
    .wdata   (wdata_i),
    .rdata   (bus.d_data_i),
    .be      (al_be),
    .wlane   (al_wlane),
    .rext    (al_rext),
    .bad     (al_bad)
  );

  assign to_hit = (TIMEOUT != 0) && (cnt == TO_LIM);

  always_comb begin
    state_n = state;
    cause_n = cause_q;
    done_o  = 1'b0;
    err_o   = 1'b0;
    case (state)
      S_IDLE: if (req_i) begin
        if (al_bad) begin
          state_n = S_FAULT;
          cause_n = CAUSE_MISALIGN;
        end else begin
          state_n = S_BUS;
        end
      end
      S_BUS: begin
        // Bus error has priority over a coincident acknowledge.
        if (bus.d_err_i) begin
          state_n = S_FAULT;
          cause_n = CAUSE_BUSERR;
        end else if (bus.d_ack_i) begin
          state_n = S_RESP;
        end else if (to_hit) begin
          state_n = S_FAULT;
          cause_n = CAUSE_TIMEOUT;
        end
      end
      S_RESP: begin
        done_o  = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        err_o   = 1'b1;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state   <= state_n;
      cause_q <= cause_n;
      if (state == S_IDLE && state_n == S_BUS) begin
        addr_q <= {addr_i[ADDR_W-1:2], 2'b00};
        data_q <= al_wlane;
        be_q   <= al_be;
        rd_q   <= ~we_i;
        wr_q   <= we_i;
        cnt    <= '0;
      end
      if (state == S_BUS) begin
        if (state_n != S_BUS) begin
          rd_q <= 1'b0;
          wr_q <= 1'b0;
        end else if (TIMEOUT != 0) begin
          cnt <= cnt + CW'(1);
        end
        if (state_n == S_RESP && rd_q) rdata_q <= al_rext;
      end
    end
  end

  assign busy_o       = req_i & ~(done_o | err_o);
  assign rdata_o      = rdata_q;
  assign err_cause_o  = cause_q;
  assign bus.d_addr_o = addr_q;
  assign bus.d_data_o = data_q;
  assign bus.d_be_o   = be_q;
  assign bus.d_rd_o   = rd_q;
  assign bus.d_wr_o   = wr_q;

endmodule

// File: tb/tb_nano_lsu_mc.sv
// Directed self-checking bench for nano_lsu_mc (TIMEOUT = 4).
module tb_nano_lsu_mc;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req_i, we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] rdata_o;
  logic        done_o, err_o, busy_o;
  logic [1:0]  err_cause_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  nano_lsu_mc_if #(.ADDR_W(32)) bus ();

  nano_lsu_mc #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .err_cause_o (err_cause_o),
    .busy_o      (busy_o),
    .bus         (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
  endtask

  task automatic idle_inputs();
    req_i = 1'b0; bus.d_ack_i = 1'b0; bus.d_err_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; idle_inputs(); we_i = 1'b0; funct3_i = 3'b000;
    addr_i = '0; wdata_i = '0; bus.d_data_i = '0;
    #12;
    n_checks++;
    if ({done_o, err_o, busy_o, bus.d_rd_o, bus.d_wr_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000",
                         {done_o, err_o, busy_o, bus.d_rd_o, bus.d_wr_o});
    end
    n_checks++;
    if ({rdata_o, err_cause_o, bus.d_be_o, bus.d_addr_o, bus.d_data_o} !== '0) begin
      n_fail++; $display("FAIL reset_data: rdata %h cause %b be %b addr %h data %h want all 0",
                         rdata_o, err_cause_o, bus.d_be_o, bus.d_addr_o, bus.d_data_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_store_byte();
    tick();
    start(1'b1, 3'b000, 32'h103, 32'h0000_00A5);
    bus.d_ack_i = 1'b1;   // ignored while IDLE, then acks the first BUS cycle
    #1;
    n_checks++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL sb_busy: got %b want 1", busy_o); end
    tick();
    n_checks++;
    if ({bus.d_wr_o, bus.d_rd_o, done_o} !== 3'b100) begin
      n_fail++; $display("FAIL sb_strobe: wr/rd/done %b want 100", {bus.d_wr_o, bus.d_rd_o, done_o});
    end
    n_checks++;
    if (bus.d_addr_o !== 32'h100 || bus.d_be_o !== 4'b1000 || bus.d_data_o !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL sb_bus: addr %h be %b data %h want 00000100 1000 a5a5a5a5",
                         bus.d_addr_o, bus.d_be_o, bus.d_data_o);
    end
    tick();
    n_checks++;
    if ({done_o, err_o, busy_o, bus.d_wr_o} !== 4'b1000) begin
      n_fail++; $display("FAIL sb_done: done/err/busy/wr %b want 1000",
                         {done_o, err_o, busy_o, bus.d_wr_o});
    end
    idle_inputs();
    tick();
    n_checks++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL sb_done_pulse: got %b want 0", done_o); end
  endtask

  task automatic test_store_half();
    start(1'b1, 3'b001, 32'h102, 32'h1234_BEEF);
    tick();
    n_checks++;
    if (bus.d_be_o !== 4'b1100 || bus.d_data_o !== 32'hBEEFBEEF || bus.d_addr_o !== 32'h100) begin
      n_fail++; $display("FAIL sh_bus: be %b data %h addr %h want 1100 beefbeef 00000100",
                         bus.d_be_o, bus.d_data_o, bus.d_addr_o);
    end
    bus.d_ack_i = 1'b1;
    tick();
    n_checks++;
    if (done_o !== 1'b1) begin n_fail++; $display("FAIL sh_done: got %b want 1", done_o); end
    idle_inputs();
    tick();
    // store with an illegal funct3 faults without touching the bus
    start(1'b1, 3'b011, 32'h100, 32'h0);
    tick();
    n_checks++;
    if ({err_o, err_cause_o, bus.d_wr_o} !== 4'b1010) begin
      n_fail++; $display("FAIL s_illegal: err/cause/wr %b want 1010", {err_o, err_cause_o, bus.d_wr_o});
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_load(input logic [2:0] f3, input logic [31:0] exp, input string nm);
    start(1'b0, f3, 32'h102, 32'h0);
    tick();
    n_checks++;
    if ({bus.d_rd_o, bus.d_wr_o, bus.d_be_o} !== 6'b101111 || bus.d_addr_o !== 32'h100) begin
      n_fail++; $display("FAIL %s_bus: rd/wr/be %b addr %h want 101111 00000100",
                         nm, {bus.d_rd_o, bus.d_wr_o, bus.d_be_o}, bus.d_addr_o);
    end
    bus.d_data_i = 32'h0080_0000; bus.d_ack_i = 1'b1;
    tick();
    n_checks++;
    if (done_o !== 1'b1 || rdata_o !== exp) begin
      n_fail++; $display("FAIL %s_data: done %b rdata %h want 1 %h", nm, done_o, rdata_o, exp);
    end
    idle_inputs(); bus.d_data_i = 32'h5555_5555;
    tick();
    n_checks++;
    if (rdata_o !== exp) begin n_fail++; $display("FAIL %s_hold: rdata %h want %h", nm, rdata_o, exp); end
  endtask

  task automatic test_misaligned();
    start(1'b0, 3'b001, 32'h101, 32'h0);
    tick();
    n_checks++;
    if ({err_o, done_o, err_cause_o, bus.d_rd_o} !== 5'b10010) begin
      n_fail++; $display("FAIL lh_misalign: err/done/cause/rd %b want 10010",
                         {err_o, done_o, err_cause_o, bus.d_rd_o});
    end
    idle_inputs();
    tick();
    n_checks++;
    if ({err_o, err_cause_o, bus.d_rd_o} !== 4'b0010) begin
      n_fail++; $display("FAIL lh_after: err/cause/rd %b want 0010", {err_o, err_cause_o, bus.d_rd_o});
    end
  endtask

  task automatic test_timeout();
    start(1'b0, 3'b010, 32'h200, 32'h0);
    tick();
    n_checks++;
    if (bus.d_rd_o !== 1'b1) begin n_fail++; $display("FAIL to_strobe: rd %b want 1", bus.d_rd_o); end
    for (int i = 2; i <= 5; i++) begin
      tick();
      n_checks++;
      if ({err_o, bus.d_rd_o} !== 2'b01) begin
        n_fail++; $display("FAIL to_wait%0d: err/rd %b want 01", i, {err_o, bus.d_rd_o});
      end
    end
    tick();
    n_checks++;
    if ({err_o, done_o, err_cause_o, bus.d_rd_o} !== 5'b10100) begin
      n_fail++; $display("FAIL to_fire: err/done/cause/rd %b want 10100",
                         {err_o, done_o, err_cause_o, bus.d_rd_o});
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_ack_err();
    start(1'b1, 3'b010, 32'h300, 32'h1234_5678);
    tick();
    n_checks++;
    if (bus.d_wr_o !== 1'b1 || bus.d_be_o !== 4'b1111 || bus.d_data_o !== 32'h12345678) begin
      n_fail++; $display("FAIL sw_bus: wr %b be %b data %h want 1 1111 12345678",
                         bus.d_wr_o, bus.d_be_o, bus.d_data_o);
    end
    bus.d_ack_i = 1'b1; bus.d_err_i = 1'b1;
    tick();
    n_checks++;
    if ({err_o, done_o, err_cause_o, bus.d_wr_o} !== 5'b10110) begin
      n_fail++; $display("FAIL sw_buserr: err/done/cause/wr %b want 10110",
                         {err_o, done_o, err_cause_o, bus.d_wr_o});
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    start(1'b0, 3'b010, 32'h400, 32'h0);
    tick();
    n_checks++;
    if (bus.d_rd_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre: rd %b want 1", bus.d_rd_o); end
    #2 rst_n_i = 1'b0;
    #1;
    n_checks++;
    if ({bus.d_rd_o, bus.d_wr_o, done_o, err_o, err_cause_o} !== 6'b0) begin
      n_fail++; $display("FAIL rst_async: rd/wr/done/err/cause %b want 000000",
                         {bus.d_rd_o, bus.d_wr_o, done_o, err_o, err_cause_o});
    end
    req_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();
    start(1'b0, 3'b010, 32'h404, 32'h0);
    tick();
    n_checks++;
    if (bus.d_rd_o !== 1'b1 || bus.d_addr_o !== 32'h404) begin
      n_fail++; $display("FAIL rst_fresh_bus: rd %b addr %h want 1 00000404", bus.d_rd_o, bus.d_addr_o);
    end
    tick();
    n_checks++;
    if (done_o !== 1'b0 || bus.d_rd_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_fresh_wait: done %b rd %b want 0 1", done_o, bus.d_rd_o);
    end
    bus.d_data_i = 32'hDEAD_BEEF; bus.d_ack_i = 1'b1;
    tick();
    n_checks++;
    if (done_o !== 1'b1 || rdata_o !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rst_fresh_done: done %b rdata %h want 1 deadbeef", done_o, rdata_o);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_store_half();
    test_load(3'b000, 32'hFFFF_FF80, "lb");
    test_load(3'b100, 32'h0000_0080, "lbu");
    test_misaligned();
    test_timeout();
    test_ack_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
